// File: rtl/control_unit_if.sv
// Handshake bundle between the sequencing controller and the datapath.
// master = controller side, slave = datapath side.
interface control_unit_if;
    logic       ce;
    logic [2:0] code_op;
    logic       carry;

    logic       load_RI;
    logic       init_PC;
    logic       inc_PC;
    logic       load_PC;
    logic       sel_adr;
    logic       mem_en;
    logic       mem_we;
    logic       load_acc;
    logic       load_carry;
    logic       init_carry;
    logic [1:0] sel_ual;
    logic       halted;

    modport master (
        input  ce, code_op, carry,
        output load_RI, init_PC, inc_PC, load_PC, sel_adr, mem_en, mem_we,
               load_acc, load_carry, init_carry, sel_ual, halted
    );

    modport slave (
        output ce, code_op, carry,
        input  load_RI, init_PC, inc_PC, load_PC, sel_adr, mem_en, mem_we,
               load_acc, load_carry, init_carry, sel_ual, halted
    );
endinterface

// File: rtl/control_unit.sv
// Four-phase instruction sequencer (fetch address, fetch load, decode, execute).
// Optional macro CU_HALT_EN makes opcode 111 park the controller in HALT until reset.
//
// state  | meaning
// INIT   | clear PC and carry after reset
// FETCH1 | PC address presented to RAM
// FETCH2 | RAM word loaded into RI, PC incremented
// DECODE | operand address presented, operand read for NOR/ADD/LDA
// EXEC   | opcode-specific strobes, then back to FETCH1
// HALT   | parked, no strobes (CU_HALT_EN only)
module control_unit (
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master bus
);
`ifdef CU_HALT_EN
    typedef enum logic [2:0] {
        S_INIT, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC, S_HALT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_INIT, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC
    } state_t;
`endif

    localparam logic [2:0] OP_NOR = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_JCC = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_NOP = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] UAL_NOR  = 2'b00;
    localparam logic [1:0] UAL_ADD  = 2'b01;
    localparam logic [1:0] UAL_PASS = 2'b10;

    state_t     state;
    state_t     state_next;

    logic       ld_ri;
    logic       clr_pc;
    logic       incr_pc;
    logic       ld_pc;
    logic       adr_sel;
    logic       mem_acc;
    logic       mem_wr;
    logic       ld_acc;
    logic       ld_carry;
    logic       clr_carry;
    logic [1:0] ual_sel;
    logic       in_halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else if (bus.ce) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ld_ri      = 1'b0;
        clr_pc     = 1'b0;
        incr_pc    = 1'b0;
        ld_pc      = 1'b0;
        adr_sel    = 1'b0;
        mem_acc    = 1'b0;
        mem_wr     = 1'b0;
        ld_acc     = 1'b0;
        ld_carry   = 1'b0;
        clr_carry  = 1'b0;
        ual_sel    = UAL_NOR;
        in_halt    = 1'b0;

        case (state)
            S_INIT: begin
                clr_pc     = 1'b1;
                clr_carry  = 1'b1;
                state_next = S_FETCH1;
            end
            S_FETCH1: begin
                mem_acc    = 1'b1;
                state_next = S_FETCH2;
            end
            S_FETCH2: begin
                ld_ri      = 1'b1;
                incr_pc    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                adr_sel    = 1'b1;
                mem_acc    = (bus.code_op == OP_NOR) || (bus.code_op == OP_ADD) ||
                             (bus.code_op == OP_LDA);
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH1;
                case (bus.code_op)
                    OP_NOR: begin
                        ual_sel = UAL_NOR;
                        ld_acc  = 1'b1;
                    end
                    OP_ADD: begin
                        ual_sel  = UAL_ADD;
                        ld_acc   = 1'b1;
                        ld_carry = 1'b1;
                    end
                    OP_STA: begin
                        adr_sel = 1'b1;
                        mem_acc = 1'b1;
                        mem_wr  = 1'b1;
                    end
                    OP_JCC: begin
                        // Taken jump when carry is clear; otherwise consume the carry.
                        ld_pc     = ~bus.carry;
                        clr_carry = bus.carry;
                    end
                    OP_LDA: begin
                        ual_sel = UAL_PASS;
                        ld_acc  = 1'b1;
                    end
                    OP_JMP: begin
                        ld_pc = 1'b1;
                    end
                    OP_NOP: begin
                    end
                    OP_HLT: begin
`ifdef CU_HALT_EN
                        state_next = S_HALT;
`endif
                    end
                    default: begin
                    end
                endcase
            end
`ifdef CU_HALT_EN
            S_HALT: begin
                in_halt    = 1'b1;
                state_next = S_HALT;
            end
`endif
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

    // Strobes are qualified by ce so a stalled phase never repeats an action;
    // the selects and halted are levels and stay ungated.
    assign bus.load_RI    = ld_ri     & bus.ce;
    assign bus.init_PC    = clr_pc    & bus.ce;
    assign bus.inc_PC     = incr_pc   & bus.ce;
    assign bus.load_PC    = ld_pc     & bus.ce;
    assign bus.mem_en     = mem_acc   & bus.ce;
    assign bus.mem_we     = mem_wr    & bus.ce;
    assign bus.load_acc   = ld_acc    & bus.ce;
    assign bus.load_carry = ld_carry  & bus.ce;
    assign bus.init_carry = clr_carry & bus.ce;
    assign bus.sel_adr    = adr_sel;
    assign bus.sel_ual    = ual_sel;
    assign bus.halted     = in_halt;
endmodule

// File: tb/tb_control_unit.sv
// Directed + randomized bench for control_unit against a phase-count reference model.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    // Model: k counts ce-active edges since reset; phase 0 = INIT, then 1..4 repeat.
    int   k = 0;
    logic m_halt = 1'b0;
    int   halt_steps = 0;
    logic [2:0] cur_op;

`ifdef CU_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int phase();
        return (k == 0) ? 0 : 1 + ((k - 1) % 4);
    endfunction

    // Packed order: load_RI init_PC inc_PC load_PC sel_adr mem_en mem_we
    //               load_acc load_carry init_carry sel_ual[1:0] halted
    function automatic logic [12:0] expected(input int ph, input logic [2:0] op,
                                             input logic c, input logic cev,
                                             input logic hlt);
        logic [9:0] s;
        logic       sa;
        logic [1:0] su;
        s  = '0;
        sa = 1'b0;
        su = 2'b00;
        if (!hlt) begin
            case (ph)
                0: begin s[8] = 1'b1; s[0] = 1'b1; end
                1: s[4] = 1'b1;
                2: begin s[9] = 1'b1; s[7] = 1'b1; end
                3: begin
                    sa = 1'b1;
                    s[4] = (op == 3'd0 || op == 3'd1 || op == 3'd4);
                end
                default: begin
                    case (op)
                        3'd0: s[2] = 1'b1;
                        3'd1: begin su = 2'b01; s[2] = 1'b1; s[1] = 1'b1; end
                        3'd2: begin sa = 1'b1; s[4] = 1'b1; s[3] = 1'b1; end
                        3'd3: if (c) s[0] = 1'b1; else s[6] = 1'b1;
                        3'd4: begin su = 2'b10; s[2] = 1'b1; end
                        3'd5: s[6] = 1'b1;
                        default: ;
                    endcase
                end
            endcase
        end
        if (!cev) s = '0;
        // s: [9]RI [8]iPC [7]incPC [6]ldPC [4]mem_en [3]we [2]acc [1]ldc [0]ic
        return {s[9], s[8], s[7], s[6], sa, s[4], s[3], s[2], s[1], s[0], su, hlt};
    endfunction

    task automatic check(input string tag);
        logic [12:0] obs;
        logic [12:0] exp;
        obs = {bus.load_RI, bus.init_PC, bus.inc_PC, bus.load_PC, bus.sel_adr,
               bus.mem_en, bus.mem_we, bus.load_acc, bus.load_carry, bus.init_carry,
               bus.sel_ual, bus.halted};
        exp = expected(phase(), bus.code_op, bus.carry, bus.ce, m_halt);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step(input logic ce_v, input logic [2:0] op_v, input logic c_v,
                        input string tag);
        bus.ce      = ce_v;
        bus.code_op = op_v;
        bus.carry   = c_v;
        @(negedge clk);
        check(tag);
        @(posedge clk);
        if (ce_v && !m_halt) begin
            if (HALT_EN && phase() == 4 && op_v == 3'd7) m_halt = 1'b1;
            else k++;
        end
        #1;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        k      = 0;
        m_halt = 1'b0;
        check(tag);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic c, input string tag);
        step(1'b1, op, c, {tag, "_fetch1"});
        step(1'b1, op, c, {tag, "_fetch2"});
        step(1'b1, op, c, {tag, "_decode"});
        step(1'b1, op, c, {tag, "_exec"});
    endtask

    initial begin
        rst         = 1'b1;
        bus.ce      = 1'b0;
        bus.code_op = 3'd0;
        bus.carry   = 1'b0;
        #2 check("reset_ce0");
        bus.ce = 1'b1;
        #1 check("reset_ce1");
        @(posedge clk);
        #1 rst = 1'b0;

        step(1'b1, 3'd1, 1'b0, "init");
        run_instr(3'd1, 1'b0, "add");
        run_instr(3'd3, 1'b0, "jcc_c0");
        run_instr(3'd3, 1'b1, "jcc_c1");
        run_instr(3'd2, 1'b0, "sta");
        run_instr(3'd0, 1'b1, "nor");
        run_instr(3'd5, 1'b0, "jmp");
        run_instr(3'd6, 1'b1, "nop");

        // LDA with a three-cycle stall in DECODE: seven cycles in total.
        step(1'b1, 3'd4, 1'b0, "lda_fetch1");
        step(1'b1, 3'd4, 1'b0, "lda_fetch2");
        for (int i = 0; i < 3; i++) step(1'b0, 3'd4, 1'b0, "lda_stall");
        step(1'b1, 3'd4, 1'b0, "lda_decode");
        step(1'b1, 3'd4, 1'b0, "lda_exec");
        step(1'b1, 3'd1, 1'b0, "lda_next_fetch1");
        step(1'b1, 3'd1, 1'b0, "pre_hlt_fetch2");
        step(1'b1, 3'd7, 1'b0, "pre_hlt_decode");
        step(1'b1, 3'd7, 1'b0, "op7_exec");
        for (int i = 0; i < 20; i++)
            step(1'(i % 3 != 0), 3'($urandom_range(0, 7)), 1'($urandom), "after_op7");
        async_reset("reset_after_op7");
        step(1'b1, 3'd0, 1'b0, "init_again");

        // Mid-instruction asynchronous reset during ADD EXEC.
        step(1'b1, 3'd1, 1'b0, "mid_fetch1");
        step(1'b1, 3'd1, 1'b0, "mid_fetch2");
        step(1'b1, 3'd1, 1'b0, "mid_decode");
        async_reset("mid_reset");
        step(1'b1, 3'd1, 1'b0, "mid_init");

        cur_op = 3'd0;
        for (int i = 0; i < 400; i++) begin
            if (phase() < 3 || m_halt) cur_op = 3'($urandom_range(0, 7));
            step(1'($urandom_range(0, 3) != 0), cur_op, 1'($urandom), "rand");
            if (m_halt) halt_steps++;
            if ($urandom_range(0, 79) == 0 || halt_steps > 8) begin
                halt_steps = 0;
                async_reset("rand_reset");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Sequencing controller for the processing unit's datapath. Runs a fixed four-phase cycle (fetch address, fetch load, decode/operand read, execute) for every instruction. Drives the instruction register load, program counter, accumulator/carry registers, ALU select and memory strobes. Decodes the 3-bit `code_op` returned by the instruction register.

## Interface
Parameters:
- none; opcode encoding is fixed (see Operation).

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ce` in 1: clock enable. When 0, state holds and every strobe output is 0.
- `code_op` in 3: opcode from the instruction register (bits 15:13 of the current instruction).
- `carry` in 1: current carry flag from the datapath.
- `load_RI` out 1: instruction register load strobe.
- `init_PC` out 1: clear program counter to 0.
- `inc_PC` out 1: increment program counter.
- `load_PC` out 1: load program counter from the instruction address field.
- `sel_adr` out 1: memory address mux. 0 selects PC, 1 selects the instruction address field.
- `mem_en` out 1: memory access enable (synchronous RAM, 1-cycle read latency).
- `mem_we` out 1: memory write enable (valid only with `mem_en`).
- `load_acc` out 1: accumulator load strobe.
- `load_carry` out 1: carry flag load strobe.
- `init_carry` out 1: clear carry flag.
- `sel_ual` out 2: ALU function. 00 = NOR, 01 = ADD, 10 = PASS B (memory operand), 11 = unused.
- `halted` out 1: controller is in HALT state.

## Operation
- States: INIT, FETCH1, FETCH2, DECODE, EXEC, HALT. Encoding is left to the implementation.
- Transitions happen only on edges where `ce`=1.
- Transition order: INIT→FETCH1→FETCH2→DECODE→EXEC→FETCH1.
- Outputs are Moore-decoded from state (plus `code_op`/`carry` in EXEC), then ANDed with `ce`. Exceptions: `sel_adr`, `sel_ual` and `halted` are not gated.
- INIT: `init_PC`=1, `init_carry`=1.
- FETCH1: `sel_adr`=0, `mem_en`=1 (PC address presented).
- FETCH2: `load_RI`=1, `inc_PC`=1. The RAM word becomes the new instruction.
- DECODE: `sel_adr`=1. `mem_en`=1 for opcodes NOR, ADD, LDA (operand read). Otherwise `mem_en`=0.
- EXEC per `code_op`:
  - 000 NOR: `sel_ual`=00, `load_acc`=1.
  - 001 ADD: `sel_ual`=01, `load_acc`=1, `load_carry`=1.
  - 010 STA: `sel_adr`=1, `mem_en`=1, `mem_we`=1.
  - 011 JCC: if `carry`=0, `load_PC`=1. If `carry`=1, `init_carry`=1 and no jump.
  - 100 LDA: `sel_ual`=10, `load_acc`=1.
  - 101 JMP: `load_PC`=1.
  - 110 NOP: no strobes.
  - 111: see Configuration.
- HALT: all strobes 0, `halted`=1. The state is left only via `rst`.
- `sel_ual` defaults to 00 and `sel_adr` defaults to 0 whenever not specified above.

## Timing
- Reset value: state INIT. All outputs 0 except `init_PC` and `init_carry`, which equal `ce` while in INIT.
- Reset asserted mid-instruction: state becomes INIT immediately (asynchronously). Strobes drop to INIT values in the same cycle. The partially executed instruction has no further effect.
- First fetch address is presented in the 2nd `ce`-active cycle after reset release.
- Instruction latency: exactly 4 `ce`-active cycles for every opcode, including taken/untaken jumps and NOP.
- Jump target reaches the PC at the EXEC edge. The next FETCH1 presents the target.
- `ce` low for N cycles in any state: that state is stretched by N cycles with no strobes. No strobe is duplicated or lost when `ce` returns.
- `code_op` is sampled only in DECODE/EXEC. It is stable there because `load_RI` fires only in FETCH2.
- `carry` is sampled combinationally in EXEC.

## Configuration
- Macro `CU_HALT_EN`, defined: opcode 111 in EXEC moves the state to HALT instead of FETCH1. `halted`=1 from the next `ce`-active edge.
- Macro `CU_HALT_EN`, undefined: opcode 111 executes as NOP. HALT state is not built, and `halted` is tied to 0.

## Test plan
- Reset then `ce`=1:
  - INIT cycle shows `init_PC`=`init_carry`=1.
  - Cycle 2 shows `mem_en`=1, `sel_adr`=0.
  - Cycle 3 shows `load_RI`=1, `inc_PC`=1.
- `code_op`=001 (ADD): DECODE shows `mem_en`=1, `sel_adr`=1. EXEC shows `sel_ual`=01, `load_acc`=1, `load_carry`=1. The following cycle is FETCH1.
- `code_op`=011 with `carry`=0: EXEC shows `load_PC`=1. With `carry`=1: EXEC shows `load_PC`=0, `init_carry`=1.
- `code_op`=010 (STA): EXEC shows `mem_en`=`mem_we`=1, `sel_adr`=1. DECODE shows `mem_en`=0.
- `ce`=0 held 3 cycles during DECODE of LDA: no strobes during the stall. EXEC follows on the first `ce`=1 edge, and total instruction time is 7 cycles.
- `code_op`=111:
  - With `CU_HALT_EN`: `halted`=1 and strobes stay 0 for 20 cycles, until `rst` pulse returns INIT.
  - Without `CU_HALT_EN`: FETCH1 follows EXEC.
